// File: rtl/hamming_secded_pkg.sv
// Shared types and codeword-layout helpers for the extended Hamming SEC-DED codec.
// Position 0 holds overall parity, powers of two hold Hamming bits, the rest carry data.
package hamming_secded_pkg;

    localparam int DATA_W = 64;
    localparam int RED_W  = 8;
    localparam int CW_W   = DATA_W + RED_W;

    typedef enum logic [1:0] {
        NONE,
        SINGLE,
        DOUBLE
    } err_e;

    function automatic logic is_pow2(input int j);
        return (j > 0) && ((j & (j - 1)) == 0);
    endfunction

    // Skip over every power-of-two slot at or below the candidate position.
    function automatic int data_pos(input int i);
        int j;
        j = i + 1;
        for (int b = 0; b < 31; b++) begin
            if ((1 << b) <= j) begin
                j = j + 1;
            end
        end
        return j;
    endfunction

    function automatic int pos_to_data(input int j);
        int lg;
        lg = 0;
        for (int b = 0; b < 31; b++) begin
            if ((1 << b) <= j) begin
                lg = b;
            end
        end
        return j - lg - 2;
    endfunction

endpackage

// File: rtl/hamming_syndrome_calc.sv
// Combinational syndrome and overall-parity computation over a full codeword.
module hamming_syndrome_calc #(
    parameter int CW = 72,
    parameter int SW = 7
) (
    input  logic [CW-1:0] codeword,
    output logic [SW-1:0] syndrome,
    output logic          parity
);

    // The syndrome is the XOR of the indices of all set bits above position 0.
    always_comb begin
        syndrome = '0;
        for (int j = 1; j < CW; j++) begin
            if (codeword[j]) begin
                syndrome = syndrome ^ SW'(j);
            end
        end
        parity = ^codeword;
    end

endmodule

// File: rtl/hamming_secded_codec.sv
// Registered SEC-DED encoder and decoder, one cycle of latency per independent path.
// Optional error counters are built when ECC_ERR_COUNT_EN is defined.
module hamming_secded_codec
    import hamming_secded_pkg::*;
#(
    parameter int data_bit_width      = DATA_W,
    parameter int redundant_bit_width = RED_W
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          enc_valid_in,
    input  logic [data_bit_width-1:0]                     enc_data_in,
    output logic                                          enc_valid_out,
    output logic [data_bit_width+redundant_bit_width-1:0] enc_data_out,
    input  logic                                          dec_valid_in,
    input  logic [data_bit_width+redundant_bit_width-1:0] dec_data_in,
    output logic                                          dec_valid_out,
    output logic [data_bit_width-1:0]                     dec_data_out,
    output logic                                          dec_single_err,
    output logic                                          dec_double_err,
`ifdef ECC_ERR_COUNT_EN
    output logic [31:0]                                   corr_cnt,
    output logic [31:0]                                   uncorr_cnt,
`endif
    output logic [redundant_bit_width-2:0]                dec_syndrome
);

    localparam int CW = data_bit_width + redundant_bit_width;
    localparam int SW = redundant_bit_width - 1;

    if ((2 ** SW) < CW) begin : g_illegal_params
        $error("hamming_secded_codec: 2^(P-1) must be >= D+P");
    end

    logic [SW-1:0] enc_syn;
    logic [CW-1:0] enc_cw;

    // Each Hamming bit is one bit of the XOR of all set data positions.
    always_comb begin
        enc_syn = '0;
        for (int i = 0; i < data_bit_width; i++) begin
            if (enc_data_in[i]) begin
                enc_syn = enc_syn ^ SW'(data_pos(i));
            end
        end
    end

    for (genvar j = 0; j < CW; j++) begin : g_enc_layout
        if (j == 0) begin : g_p0
            assign enc_cw[j] = ^{enc_syn, enc_data_in};
        end else if (is_pow2(j)) begin : g_hamming
            assign enc_cw[j] = enc_syn[$clog2(j)];
        end else begin : g_data
            assign enc_cw[j] = enc_data_in[pos_to_data(j)];
        end
    end

    logic [SW-1:0]             dec_syn;
    logic                      dec_par;
    err_e                      dec_err;
    logic [data_bit_width-1:0] dec_fix;

    hamming_syndrome_calc #(
        .CW(CW),
        .SW(SW)
    ) u_syndrome (
        .codeword(dec_data_in),
        .syndrome(dec_syn),
        .parity  (dec_par)
    );

    // Odd parity with an in-range syndrome is one flipped bit; anything else nonzero is fatal.
    always_comb begin
        dec_err = NONE;
        if (dec_par) begin
            dec_err = (int'(dec_syn) < CW) ? SINGLE : DOUBLE;
        end else if (dec_syn != '0) begin
            dec_err = DOUBLE;
        end
    end

    for (genvar i = 0; i < data_bit_width; i++) begin : g_dec_extract
        localparam int POS = data_pos(i);
        assign dec_fix[i] = dec_data_in[POS] ^ ((dec_err == SINGLE) && (dec_syn == SW'(POS)));
    end

    logic                      enc_valid_d, enc_valid_q;
    logic [CW-1:0]             enc_data_d, enc_data_q;
    logic                      dec_valid_d, dec_valid_q;
    logic [data_bit_width-1:0] dec_data_d, dec_data_q;
    logic                      dec_single_d, dec_single_q;
    logic                      dec_double_d, dec_double_q;
    logic [SW-1:0]             dec_syn_d, dec_syn_q;

    always_comb begin
        enc_valid_d  = enc_valid_in;
        enc_data_d   = enc_cw;
        dec_valid_d  = dec_valid_in;
        dec_data_d   = dec_fix;
        dec_single_d = dec_valid_in && (dec_err == SINGLE);
        dec_double_d = dec_valid_in && (dec_err == DOUBLE);
        dec_syn_d    = dec_syn;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enc_valid_q  <= 1'b0;
            enc_data_q   <= '0;
            dec_valid_q  <= 1'b0;
            dec_data_q   <= '0;
            dec_single_q <= 1'b0;
            dec_double_q <= 1'b0;
            dec_syn_q    <= '0;
        end else begin
            enc_valid_q  <= enc_valid_d;
            enc_data_q   <= enc_data_d;
            dec_valid_q  <= dec_valid_d;
            dec_data_q   <= dec_data_d;
            dec_single_q <= dec_single_d;
            dec_double_q <= dec_double_d;
            dec_syn_q    <= dec_syn_d;
        end
    end

    assign enc_valid_out  = enc_valid_q;
    assign enc_data_out   = enc_data_q;
    assign dec_valid_out  = dec_valid_q;
    assign dec_data_out   = dec_data_q;
    assign dec_single_err = dec_single_q;
    assign dec_double_err = dec_double_q;
    assign dec_syndrome   = dec_syn_q;

`ifdef ECC_ERR_COUNT_EN
    logic [31:0] corr_cnt_d, corr_cnt_q;
    logic [31:0] uncorr_cnt_d, uncorr_cnt_q;

    // Counters follow the registered flags and hold once they reach all-ones.
    always_comb begin
        corr_cnt_d   = corr_cnt_q;
        uncorr_cnt_d = uncorr_cnt_q;
        if (dec_valid_q && dec_single_q && (corr_cnt_q != '1)) begin
            corr_cnt_d = corr_cnt_q + 32'd1;
        end
        if (dec_valid_q && dec_double_q && (uncorr_cnt_q != '1)) begin
            uncorr_cnt_d = uncorr_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
        end else begin
            corr_cnt_q   <= corr_cnt_d;
            uncorr_cnt_q <= uncorr_cnt_d;
        end
    end

    assign corr_cnt   = corr_cnt_q;
    assign uncorr_cnt = uncorr_cnt_q;
`endif

endmodule

// File: tb/tb_hamming_secded_codec.sv
// Scoreboard bench for hamming_secded_codec; counter checks build with ECC_ERR_COUNT_EN.
module tb_hamming_secded_codec;

    typedef struct packed {
        logic [63:0] data;
        logic        single;
        logic        dbl;
        logic [6:0]  syn;
    } dec_exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enc_valid_in = 1'b0;
    logic [63:0] enc_data_in = '0;
    logic        enc_valid_out;
    logic [71:0] enc_data_out;
    logic        dec_valid_in = 1'b0;
    logic [71:0] dec_data_in = '0;
    logic        dec_valid_out;
    logic [63:0] dec_data_out;
    logic        dec_single_err;
    logic        dec_double_err;
    logic [6:0]  dec_syndrome;
`ifdef ECC_ERR_COUNT_EN
    logic [31:0] corr_cnt;
    logic [31:0] uncorr_cnt;
`endif

    int check_count = 0;
    int pass_count  = 0;

    logic [71:0] enc_q[$];
    dec_exp_t    dec_q[$];

    hamming_secded_codec dut (
        .clk           (clk),
        .rst           (rst),
        .enc_valid_in  (enc_valid_in),
        .enc_data_in   (enc_data_in),
        .enc_valid_out (enc_valid_out),
        .enc_data_out  (enc_data_out),
        .dec_valid_in  (dec_valid_in),
        .dec_data_in   (dec_data_in),
        .dec_valid_out (dec_valid_out),
        .dec_data_out  (dec_data_out),
        .dec_single_err(dec_single_err),
        .dec_double_err(dec_double_err),
`ifdef ECC_ERR_COUNT_EN
        .corr_cnt      (corr_cnt),
        .uncorr_cnt    (uncorr_cnt),
`endif
        .dec_syndrome  (dec_syndrome)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [71:0] observed, input logic [71:0] expected);
        check_count++;
        if (observed === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [71:0] model_encode(input logic [63:0] d);
        logic [71:0] cw;
        logic        p;
        int          k;
        cw = '0;
        k  = 0;
        for (int j = 1; j < 72; j++) begin
            if ((j & (j - 1)) != 0) begin
                cw[j] = d[k];
                k++;
            end
        end
        for (int b = 0; b < 7; b++) begin
            p = 1'b0;
            for (int j = 1; j < 72; j++) begin
                if ((((j >> b) & 1) == 1) && ((j & (j - 1)) != 0)) begin
                    p = p ^ cw[j];
                end
            end
            cw[1 << b] = p;
        end
        cw[0] = ^cw;
        return cw;
    endfunction

    function automatic logic [63:0] model_extract(input logic [71:0] cw);
        logic [63:0] d;
        int          k;
        d = '0;
        k = 0;
        for (int j = 1; j < 72; j++) begin
            if ((j & (j - 1)) != 0) begin
                d[k] = cw[j];
                k++;
            end
        end
        return d;
    endfunction

    function automatic dec_exp_t make_exp(input logic [63:0] d, input logic s, input logic db, input logic [6:0] syn);
        dec_exp_t e;
        e.data   = d;
        e.single = s;
        e.dbl    = db;
        e.syn    = syn;
        return e;
    endfunction

    task automatic applyStimulus(input logic ev, input logic [63:0] ed, input logic [71:0] enc_exp,
                                 input logic dv, input logic [71:0] dcw, input dec_exp_t de);
        @(posedge clk);
        #2;
        enc_valid_in = ev;
        enc_data_in  = ed;
        dec_valid_in = dv;
        dec_data_in  = dcw;
        if (ev) enc_q.push_back(enc_exp);
        if (dv) dec_q.push_back(de);
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #2;
            enc_valid_in = 1'b0;
            dec_valid_in = 1'b0;
        end
    endtask

    task automatic wait_drain();
        idle(1);
        for (int c = 0; c < 20 && (enc_q.size() != 0 || dec_q.size() != 0); c++) begin
            @(posedge clk);
        end
        #2;
        checkOutput("scoreboard_drained", 72'(enc_q.size() + dec_q.size()), 72'd0);
    endtask

    always @(posedge clk) begin
        logic [71:0] ee;
        dec_exp_t    de;
        #1;
        if (!rst) begin
            if (enc_valid_out) begin
                if (enc_q.size() == 0) begin
                    checkOutput("enc_unexpected_valid", 72'd1, 72'd0);
                end else begin
                    ee = enc_q.pop_front();
                    checkOutput("enc_codeword", enc_data_out, ee);
                end
            end
            if (dec_valid_out) begin
                if (dec_q.size() == 0) begin
                    checkOutput("dec_unexpected_valid", 72'd1, 72'd0);
                end else begin
                    de = dec_q.pop_front();
                    checkOutput("dec_data", 72'(dec_data_out), 72'(de.data));
                    checkOutput("dec_single_err", 72'(dec_single_err), 72'(de.single));
                    checkOutput("dec_double_err", 72'(dec_double_err), 72'(de.dbl));
                    checkOutput("dec_syndrome", 72'(dec_syndrome), 72'(de.syn));
                end
            end else begin
                checkOutput("dec_flags_idle", 72'({dec_single_err, dec_double_err}), 72'd0);
            end
        end
    end

    initial begin
        logic [63:0] d;
        logic [71:0] cw;
        logic [71:0] bad;
        logic [63:0] ones;
        ones = '1;

        #1 rst = 1'b1;
        #2;
        checkOutput("reset_outputs", 72'({enc_valid_out, dec_valid_out, dec_single_err, dec_double_err,
                    dec_syndrome, enc_data_out != '0, dec_data_out != '0}), 72'd0);
        #20 rst = 1'b0;

        applyStimulus(1'b1, 64'h0, 72'h0, 1'b1, 72'h00F, make_exp(64'h1, 1'b0, 1'b0, 7'd0));
        applyStimulus(1'b1, 64'h1, 72'h00F, 1'b1, 72'h007, make_exp(64'h1, 1'b1, 1'b0, 7'd3));
        applyStimulus(1'b1, ones, model_encode(ones), 1'b1, 72'h00E, make_exp(64'h1, 1'b1, 1'b0, 7'd0));
        applyStimulus(1'b0, 64'h0, 72'h0, 1'b1, 72'h009, make_exp(64'h1, 1'b0, 1'b1, 7'd3));
        applyStimulus(1'b0, 64'h0, 72'h0, 1'b1, model_encode(ones), make_exp(ones, 1'b0, 1'b0, 7'd0));
        wait_drain();

        d = 64'hDEAD_BEEF_0123_4567;
        applyStimulus(1'b1, d, model_encode(d), 1'b1, model_encode(d), make_exp(d, 1'b0, 1'b0, 7'd0));
        @(posedge clk);
        #4;
        checkOutput("pre_reset_valid", 72'({enc_valid_out, dec_valid_out}), 72'b11);
        rst = 1'b1;
        #1;
        checkOutput("midreset_valids", 72'({enc_valid_out, dec_valid_out}), 72'd0);
        checkOutput("midreset_enc_data", enc_data_out, 72'd0);
        checkOutput("midreset_dec_data", 72'(dec_data_out), 72'd0);
        checkOutput("midreset_dec_status", 72'({dec_single_err, dec_double_err, dec_syndrome}), 72'd0);
`ifdef ECC_ERR_COUNT_EN
        checkOutput("midreset_counters", 72'({corr_cnt, uncorr_cnt}), 72'd0);
`endif
        enc_valid_in = 1'b0;
        dec_valid_in = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #5;
        enc_q.delete();
        dec_q.delete();
        rst = 1'b0;
        idle(1);
        applyStimulus(1'b1, d, model_encode(d), 1'b1, model_encode(d), make_exp(d, 1'b0, 1'b0, 7'd0));
        wait_drain();

        for (int i = 0; i < 72; i++) begin
            d   = {$urandom, $urandom};
            cw  = model_encode(d);
            bad = cw ^ (72'd1 << i);
            applyStimulus(1'b1, d, cw, 1'b1, bad, make_exp(d, 1'b1, 1'b0, 7'(i)));
        end
        d   = {$urandom, $urandom};
        bad = model_encode(d) ^ (72'd1 << 5) ^ (72'd1 << 20);
        applyStimulus(1'b0, 64'h0, 72'h0, 1'b1, bad, make_exp(model_extract(bad), 1'b0, 1'b1, 7'd17));
        wait_drain();
`ifdef ECC_ERR_COUNT_EN
        checkOutput("corr_cnt", 72'(corr_cnt), 72'd72);
        checkOutput("uncorr_cnt", 72'(uncorr_cnt), 72'd1);
`endif

        bad = model_encode(ones) ^ (72'd1 << 64) ^ (72'd1 << 8) ^ 72'd1;
        applyStimulus(1'b0, 64'h0, 72'h0, 1'b1, bad, make_exp(model_extract(bad), 1'b0, 1'b1, 7'd72));
        wait_drain();

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
